// File: rtl/data_ram_responder.sv
// Far-end data memory for the processor's DRAM port: fixed-latency 8-bit reads/writes
// with completion signalling, plus an exclusive host port for preload and result dump.
module data_ram_responder #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 65536,
   parameter int RD_LAT = 2,
   parameter int WR_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic              busy,
   output logic              err,
   input  logic              host_sel,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata
);

   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [ADDR_W:0]  DEPTH_LIM = DEPTH[ADDR_W:0];
   localparam logic [CNT_W-1:0] RD_CNT    = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] WR_CNT    = CNT_W'(WR_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      HOST    = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [DATA_W-1:0]   din_reg, din_next;
   logic                first_cyc_reg, first_cyc_next;
   logic                rd_valid_reg, rd_valid_next;
   logic                err_reg, err_next;
   logic                pdata_ok_reg, pdata_ok_next;
   logic                hdata_ok_reg, hdata_ok_next;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];
   logic [DATA_W-1:0]   pdata_reg;
   logic [DATA_W-1:0]   hdata_reg;

   logic                mem_we;
   logic [IDX_W-1:0]    mem_widx;
   logic [DATA_W-1:0]   mem_wdata;
   logic                pdata_en;
   logic                hdata_en;
   logic                accept;

   logic                addr_ok;
   logic                host_ok;
   logic [IDX_W-1:0]    addr_idx;
   logic [IDX_W-1:0]    host_idx;

   // Range checks use every address bit, so high addresses never alias low words.
   assign addr_ok  = ({1'b0, addr_reg}  < DEPTH_LIM);
   assign host_ok  = ({1'b0, host_addr} < DEPTH_LIM);
   assign addr_idx = addr_reg[IDX_W-1:0];
   assign host_idx = host_addr[IDX_W-1:0];

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      addr_next      = addr_reg;
      din_next       = din_reg;
      first_cyc_next = 1'b0;
      rd_valid_next  = 1'b0;
      err_next       = 1'b0;
      pdata_ok_next  = pdata_ok_reg;
      hdata_ok_next  = hdata_ok_reg;
      mem_we         = 1'b0;
      mem_widx       = addr_idx;
      mem_wdata      = din_reg;
      pdata_en       = 1'b0;
      hdata_en       = 1'b0;
      accept         = 1'b0;

      case (state_reg)
         IDLE: begin
            accept = 1'b1;
         end
         RD_WAIT: begin
            if (cnt_reg == CNT_ONE) begin
               pdata_en      = addr_ok;
               pdata_ok_next = addr_ok;
               rd_valid_next = 1'b1;
               err_next      = !addr_ok;
               state_next    = IDLE;
               accept        = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
               // A read strobe still held right after sampling is the same request.
               err_next = first_cyc_reg ? write : (read | write);
            end
         end
         WR_WAIT: begin
            if (cnt_reg == CNT_ONE) begin
               mem_we     = addr_ok;
               err_next   = !addr_ok;
               state_next = IDLE;
               accept     = 1'b1;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
               err_next = first_cyc_reg ? read : (read | write);
            end
         end
         HOST: begin
            mem_we        = host_sel & host_we & host_ok;
            mem_widx      = host_idx;
            mem_wdata     = host_wdata;
            hdata_en      = host_ok;
            hdata_ok_next = host_ok;
            err_next      = read | write;
            if (!host_sel) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A completing operation hands the same edge to the next request.
      if (accept) begin
         if (host_sel) begin
            state_next = HOST;
         end else if (read ^ write) begin
            state_next     = read ? RD_WAIT : WR_WAIT;
            cnt_next       = read ? RD_CNT : WR_CNT;
            addr_next      = addr;
            din_next       = din;
            first_cyc_next = 1'b1;
         end else if (read & write) begin
            err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         din_reg       <= '0;
         first_cyc_reg <= 1'b0;
         rd_valid_reg  <= 1'b0;
         err_reg       <= 1'b0;
         pdata_ok_reg  <= 1'b0;
         hdata_ok_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         addr_reg      <= addr_next;
         din_reg       <= din_next;
         first_cyc_reg <= first_cyc_next;
         rd_valid_reg  <= rd_valid_next;
         err_reg       <= err_next;
         pdata_ok_reg  <= pdata_ok_next;
         hdata_ok_reg  <= hdata_ok_next;
      end
   end

   // Storage and its read registers stay reset-free; the ok flags mask them to zero.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_widx] <= mem_wdata;
      end
      if (pdata_en) begin
         pdata_reg <= mem[addr_idx];
      end
      if (hdata_en) begin
         hdata_reg <= mem[host_idx];
      end
   end

   assign dout       = pdata_ok_reg ? pdata_reg : '0;
   assign host_rdata = hdata_ok_reg ? hdata_reg : '0;
   assign rd_valid   = rd_valid_reg;
   assign err        = err_reg;
   assign busy       = (state_reg != IDLE);

endmodule
